// File: rtl/lat_fsm_pkg.sv
// Shared controller encoding and table-entry layout helpers for the
// serially programmed look-at-table FSM.
package lat_fsm_pkg;

  typedef enum logic [1:0] {
    CTL_HALT = 2'd0,
    CTL_CFG  = 2'd1,
    CTL_RUN  = 2'd2
  } ctl_e;

  // Default geometry; modules recompute these from their own parameters.
  localparam int DEF_IN_W    = 5;
  localparam int DEF_STATE_W = 3;
  localparam int DEF_OUT_W   = 5;

  // Entry layout, MSB to LSB: timed | match | nxt_hit | nxt_miss | out_val
  function automatic int E(int in_w, int state_w, int out_w);
    return 1 + in_w + 2 * state_w + out_w;
  endfunction

  localparam int OFF_OUT = 0;

  function automatic int off_miss(int out_w);
    return out_w;
  endfunction

  function automatic int off_hit(int state_w, int out_w);
    return out_w + state_w;
  endfunction

  function automatic int off_match(int state_w, int out_w);
    return out_w + 2 * state_w;
  endfunction

  function automatic int off_timed(int in_w, int state_w, int out_w);
    return E(in_w, state_w, out_w) - 1;
  endfunction

  localparam int DEF_E = E(DEF_IN_W, DEF_STATE_W, DEF_OUT_W);

endpackage

// File: rtl/lat_fsm_prog_if.sv
// Config/run/output bundle of the look-at-table FSM; master drives, slave is the FSM.
interface lat_fsm_prog_if #(
  parameter int STATE_W = 3,
  parameter int IN_W    = 5,
  parameter int OUT_W   = 5
);
  logic               cfg_start;
  logic               cfg_en;
  logic               cfg_bit;
  logic               run;
  logic [IN_W-1:0]    in;
  logic [OUT_W-1:0]   out;
  logic [STATE_W-1:0] state;
  logic               loaded;
  logic               cfg_busy;
  logic               timer_exp;

  modport master (
    output cfg_start, cfg_en, cfg_bit, run, in,
    input  out, state, loaded, cfg_busy, timer_exp
  );

  modport slave (
    input  cfg_start, cfg_en, cfg_bit, run, in,
    output out, state, loaded, cfg_busy, timer_exp
  );
endinterface

// File: rtl/lat_cfg_loader.sv
// Serial table loader: shifts the entry stream into the table bit array and
// flags completion. Entry 0 first, each entry MSB first.
module lat_cfg_loader
  import lat_fsm_pkg::*;
#(
  parameter int N_STATES = 8,
  parameter int STATE_W  = 3,
  parameter int EW       = DEF_E
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         cfg_start,
  input  logic                         cfg_en,
  input  logic                         cfg_bit,
  output logic [N_STATES-1:0][EW-1:0] tbl,
  output logic                         loaded,
  output logic                         cfg_busy,
  output logic                         load_done
);
  localparam int BIT_W = $clog2(EW);

  // The stream position is kept as (entry, bit-within-entry) so the write
  // decode needs no divider.
  logic [STATE_W-1:0] ent;
  logic [BIT_W-1:0]   bit_i;
  logic               wr;

  assign wr        = cfg_busy && cfg_en && !cfg_start;
  assign load_done = wr && (ent == STATE_W'(N_STATES - 1)) && (bit_i == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tbl      <= '0;
      ent      <= '0;
      bit_i    <= BIT_W'(EW - 1);
      loaded   <= 1'b0;
      cfg_busy <= 1'b0;
    end else if (cfg_start) begin
      ent      <= '0;
      bit_i    <= BIT_W'(EW - 1);
      loaded   <= 1'b0;
      cfg_busy <= 1'b1;
    end else if (wr) begin
      tbl[ent][bit_i] <= cfg_bit;
      if (bit_i == '0) begin
        bit_i <= BIT_W'(EW - 1);
        ent   <= ent + 1'b1;
      end else begin
        bit_i <= bit_i - 1'b1;
      end
      if (load_done) begin
        loaded   <= 1'b1;
        cfg_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lat_fsm_prog.sv
// Programmable look-at-table FSM: controller, table-driven next state/output
// and dwell timer on top of the serial table loader.
module lat_fsm_prog
  import lat_fsm_pkg::*;
#(
  parameter int N_STATES = 8,
  parameter int STATE_W  = 3,
  parameter int IN_W     = 5,
  parameter int OUT_W    = 5,
  parameter int TMR_W    = 20,
  parameter int TIMEOUT  = 1000
) (
  input  logic           clk,
  input  logic           nrst,
  lat_fsm_prog_if.slave  bus
);
  localparam int EW      = E(IN_W, STATE_W, OUT_W);
  localparam int O_MISS  = off_miss(OUT_W);
  localparam int O_HIT   = off_hit(STATE_W, OUT_W);
  localparam int O_MATCH = off_match(STATE_W, OUT_W);
  localparam int O_TIMED = off_timed(IN_W, STATE_W, OUT_W);

  logic [N_STATES-1:0][EW-1:0] tbl;
  logic                        loaded;
  logic                        cfg_busy;
  logic                        load_done;

  lat_cfg_loader #(
    .N_STATES (N_STATES),
    .STATE_W  (STATE_W),
    .EW       (EW)
  ) u_loader (
    .clk       (clk),
    .nrst      (nrst),
    .cfg_start (bus.cfg_start),
    .cfg_en    (bus.cfg_en),
    .cfg_bit   (bus.cfg_bit),
    .tbl       (tbl),
    .loaded    (loaded),
    .cfg_busy  (cfg_busy),
    .load_done (load_done)
  );

  ctl_e               ctl;
  logic [STATE_W-1:0] state_q;
  logic [OUT_W-1:0]   out_q;
  logic [TMR_W-1:0]   tmr;
  logic               exp_q;

  logic [STATE_W-1:0] nxt_raw;
  logic [STATE_W-1:0] nxt;
  logic [OUT_W-1:0]   nxt_out;
  logic               hit;
  logic               expire;
  logic               take;
  logic               step;

  assign step = (ctl != CTL_CFG) && loaded && bus.run;

  // Hit beats expiry; a timed state without hit or expiry stays put and keeps counting.
  always_comb begin
    hit     = (bus.in == tbl[state_q][O_MATCH +: IN_W]);
    expire  = 1'b0;
    take    = 1'b1;
    nxt_raw = tbl[state_q][O_MISS +: STATE_W];
    if (hit) begin
      nxt_raw = tbl[state_q][O_HIT +: STATE_W];
    end else if (tbl[state_q][O_TIMED]) begin
      if (tmr == TMR_W'(TIMEOUT - 1)) begin
        expire = 1'b1;
      end else begin
        take    = 1'b0;
        nxt_raw = state_q;
      end
    end
    nxt     = (32'(nxt_raw) >= N_STATES) ? '0 : nxt_raw;
    nxt_out = tbl[nxt][OFF_OUT +: OUT_W];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctl     <= CTL_HALT;
      state_q <= '0;
      out_q   <= '0;
      tmr     <= '0;
      exp_q   <= 1'b0;
    end else if (bus.cfg_start) begin
      ctl     <= CTL_CFG;
      state_q <= '0;
      out_q   <= '0;
      tmr     <= '0;
      exp_q   <= 1'b0;
    end else begin
      exp_q <= 1'b0;
      case (ctl)
        CTL_CFG: if (load_done) ctl <= CTL_HALT;
        default: begin
          if (step) begin
            ctl     <= CTL_RUN;
            state_q <= nxt;
            out_q   <= nxt_out;
            exp_q   <= expire;
            if (take)              tmr <= '0;
            else if (tmr != '1)    tmr <= tmr + 1'b1;
          end else begin
            ctl <= CTL_HALT;
          end
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.out       = out_q;
  assign bus.timer_exp = exp_q;
  assign bus.loaded    = loaded;
  assign bus.cfg_busy  = cfg_busy;

endmodule
